// File: rtl/control_sequencer.sv
// control_sequencer: five-step microcode sequencer that decodes the step, opcode and halt flag into a 16-bit control word.
// The control word is combinational; only the step counter and the sticky halt flag are registered.
module control_sequencer (
    input  logic        clk,
    input  logic        clr,
    input  logic [3:0]  opcode,
    output logic [15:0] ctrl,
    output logic [2:0]  t_state,
    output logic        halted
);
    typedef enum logic [2:0] {T0, T1, T2, T3, T4} step_t;

    localparam logic [15:0] HLT = 16'h8000, MI = 16'h4000, RI = 16'h2000, RO = 16'h1000;
    localparam logic [15:0] IO  = 16'h0800, II = 16'h0400, AI = 16'h0200, AO = 16'h0100;
    localparam logic [15:0] EO  = 16'h0080, SU = 16'h0040, BI = 16'h0020, OI = 16'h0010;
    localparam logic [15:0] CE  = 16'h0008, CO = 16'h0004, J  = 16'h0002;

    step_t step, step_n;
    logic  halted_n;

    always_ff @(posedge clk) begin
        if (clr) begin
            step   <= T0;
            halted <= 1'b0;
        end else begin
            step   <= step_n;
            halted <= halted_n;
        end
    end

    // An illegal step value recovers to T0 even while halted.
    always_comb begin
        step_n   = step;
        halted_n = halted;
        if (step > T4)
            step_n = T0;
        else if (!halted) begin
            if (step == T2 && opcode == 4'hF)
                halted_n = 1'b1;
            else
                step_n = (step == T4) ? T0 : step_t'(step + 3'd1);
        end
    end

    always_comb begin
        ctrl = 16'h0000;
        if (step > T4)
            ctrl = 16'h0000;
        else if (halted)
            ctrl = HLT;
        else
            case (step)
                T0: ctrl = CO | MI;
                T1: ctrl = RO | II | CE;
                T2:
                    case (opcode)
                        4'h1, 4'h2, 4'h3, 4'h4: ctrl = IO | MI;
                        4'h5:    ctrl = IO | AI;
                        4'h6:    ctrl = IO | J;
                        4'hE:    ctrl = AO | OI;
                        4'hF:    ctrl = HLT;
                        default: ctrl = 16'h0000;
                    endcase
                T3:
                    case (opcode)
                        4'h1:       ctrl = RO | AI;
                        4'h2, 4'h3: ctrl = RO | BI;
                        4'h4:       ctrl = AO | RI;
                        default:    ctrl = 16'h0000;
                    endcase
                T4:
                    case (opcode)
                        4'h2:    ctrl = EO | AI;
                        4'h3:    ctrl = EO | AI | SU;
                        default: ctrl = 16'h0000;
                    endcase
                default: ctrl = 16'h0000;
            endcase
    end

    assign t_state = step;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed and randomized checks of control_sequencer against a table-driven reference model.
module tb_control_sequencer;
    logic        clk = 1'b0;
    logic        clr;
    logic [3:0]  opcode;
    logic [15:0] ctrl;
    logic [2:0]  t_state;
    logic        halted;

    int checks = 0;
    int errors = 0;
    int m_step;
    bit m_halt;
    logic [15:0] tbl [16][3];

    control_sequencer dut (
        .clk(clk), .clr(clr), .opcode(opcode),
        .ctrl(ctrl), .t_state(t_state), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_ctrl(input logic [3:0] op);
        if (m_halt) return 16'h8000;
        if (m_step == 0) return 16'h4004;
        if (m_step == 1) return 16'h1408;
        return tbl[op][m_step - 2];
    endfunction

    task automatic lit(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Apply inputs mid-cycle and compare all outputs with the model.
    task automatic drive(input logic c, input logic [3:0] op);
        clr = c;
        opcode = op;
        #1;
        lit("model_ctrl", ctrl, exp_ctrl(op));
        lit("model_tstate", {13'd0, t_state}, 16'(m_step));
        lit("model_halted", {15'd0, halted}, {15'd0, m_halt});
    endtask

    task automatic edge_step();
        @(posedge clk);
        if (clr) begin
            m_step = 0;
            m_halt = 0;
        end else if (!m_halt) begin
            if (m_step == 2 && opcode == 4'hF) m_halt = 1;
            else m_step = (m_step + 1) % 5;
        end
        #1;
    endtask

    task automatic step_op(input logic [3:0] op);
        drive(1'b0, op);
        edge_step();
    endtask

    initial begin
        logic [3:0] rop;
        logic [15:0] add_seq [5];
        add_seq = '{16'h4004, 16'h1408, 16'h4800, 16'h1020, 16'h0280};
        for (int i = 0; i < 16; i++)
            for (int k = 0; k < 3; k++) tbl[i][k] = 16'h0000;
        tbl[1]  = '{16'h4800, 16'h1200, 16'h0000};
        tbl[2]  = '{16'h4800, 16'h1020, 16'h0280};
        tbl[3]  = '{16'h4800, 16'h1020, 16'h02C0};
        tbl[4]  = '{16'h4800, 16'h2100, 16'h0000};
        tbl[5]  = '{16'h0A00, 16'h0000, 16'h0000};
        tbl[6]  = '{16'h0802, 16'h0000, 16'h0000};
        tbl[14] = '{16'h0110, 16'h0000, 16'h0000};
        tbl[15] = '{16'h8000, 16'h0000, 16'h0000};

        clr = 1'b1;
        opcode = 4'h0;
        @(posedge clk);
        #1;
        m_step = 0;
        m_halt = 0;

        repeat (3) begin
            drive(1'b1, 4'($urandom));
            lit("clr_hold_ctrl", ctrl, 16'h4004);
            edge_step();
        end

        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 4'h2);
            lit("add_ctrl", ctrl, add_seq[k]);
            lit("add_tstate", {13'd0, t_state}, 16'(k));
            edge_step();
        end
        drive(1'b0, 4'h2);
        lit("add_wrap", ctrl, 16'h4004);

        repeat (4) step_op(4'h3);
        drive(1'b0, 4'h3);
        lit("sub_t4", ctrl, 16'h02C0);
        edge_step();
        repeat (3) step_op(4'h4);
        drive(1'b0, 4'h4);
        lit("sta_t3", ctrl, 16'h2100);
        edge_step();
        step_op(4'h4);

        step_op(4'hF);
        step_op(4'hF);
        drive(1'b0, 4'hF);
        lit("hlt_t2", ctrl, 16'h8000);
        edge_step();
        repeat (10) begin
            drive(1'b0, 4'h1);
            lit("halt_ctrl", ctrl, 16'h8000);
            lit("halt_tstate", {13'd0, t_state}, 16'd2);
            lit("halt_flag", {15'd0, halted}, 16'd1);
            edge_step();
        end
        drive(1'b1, 4'h1);
        edge_step();
        drive(1'b0, 4'h1);
        lit("unhalt_ctrl", ctrl, 16'h4004);
        lit("unhalt_flag", {15'd0, halted}, 16'd0);
        edge_step();
        drive(1'b0, 4'h1);
        lit("resume_tstate", {13'd0, t_state}, 16'd1);
        edge_step();
        repeat (3) step_op(4'h1);

        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 4'hA);
            lit("undef_ctrl", ctrl, (k == 0) ? 16'h4004 : (k == 1) ? 16'h1408 : 16'h0000);
            edge_step();
        end
        drive(1'b0, 4'hA);
        lit("undef_wrap", ctrl, 16'h4004);

        repeat (3) step_op(4'h2);
        drive(1'b1, 4'h2);
        lit("abort_t3", ctrl, 16'h1020);
        edge_step();
        drive(1'b0, 4'h2);
        lit("abort_ctrl", ctrl, 16'h4004);
        lit("abort_tstate", {13'd0, t_state}, 16'd0);
        edge_step();

        rop = 4'h0;
        repeat (400) begin
            if (m_step == 0) rop = 4'($urandom);
            drive(($urandom_range(0, 29) == 0), rop);
            edge_step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
